// File: rtl/clock_pkg.sv
// clock_pkg: shared types and limits for the digital clock datapath and the
// display scanner that consumes its digits.
//   bcd_t      - one BCD digit (0-9)
//   mode_t     - user mode encoding shown on mode_state
//   bcd_inc60  - increment a two-digit BCD value modulo 60
//   bcd_inc24  - increment a two-digit BCD hour modulo 24
//   bcd_is59   - true when a two-digit BCD value is 59
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'b00,
    MODE_MIN   = 2'b01,
    MODE_HR    = 2'b10
  } mode_t;

  localparam bcd_t BCD_ONES_MAX = 4'd9;
  localparam bcd_t BCD_TENS_MAX = 4'd5;
  localparam int   HOUR_MAX     = 23;

  localparam bcd_t HOUR_TENS_MAX    = bcd_t'(HOUR_MAX / 10);
  localparam bcd_t HOUR_ONES_AT_MAX = bcd_t'(HOUR_MAX % 10);

  function automatic logic bcd_is59(input bcd_t tens, input bcd_t ones);
    return (tens == BCD_TENS_MAX) && (ones == BCD_ONES_MAX);
  endfunction

  function automatic logic [7:0] bcd_inc60(input bcd_t tens, input bcd_t ones);
    if (ones != BCD_ONES_MAX) return {tens, ones + 4'd1};
    if (tens == BCD_TENS_MAX) return 8'h00;
    return {tens + 4'd1, 4'd0};
  endfunction

  function automatic logic [7:0] bcd_inc24(input bcd_t tens, input bcd_t ones);
    if ((tens == HOUR_TENS_MAX) && (ones == HOUR_ONES_AT_MAX)) return 8'h00;
    if (ones == BCD_ONES_MAX) return {tens + 4'd1, 4'd0};
    return {tens, ones + 4'd1};
  endfunction

endpackage

// File: rtl/clock_time_core_if.sv
// clock_time_core_if: digit/status bundle from the timekeeping core to the
// display scanner.
//   dig3..dig0  - BCD HH:MM digits (dig3 = hour tens)
//   mode_state  - current mode_t encoding
//   blink_mask  - per-digit blank request, bit n = digN
//   colon       - colon LED enable
//   sec_tick    - one-cycle pulse per second
// master = producer (clock_time_core), slave = consumer (scanner).
interface clock_time_core_if;
  import clock_pkg::*;

  bcd_t       dig3;
  bcd_t       dig2;
  bcd_t       dig1;
  bcd_t       dig0;
  logic [1:0] mode_state;
  logic [3:0] blink_mask;
  logic       colon;
  logic       sec_tick;

  modport master (
    output dig3, dig2, dig1, dig0, mode_state, blink_mask, colon, sec_tick
  );

  modport slave (
    input dig3, dig2, dig1, dig0, mode_state, blink_mask, colon, sec_tick
  );

endinterface

// File: rtl/clock_time_core_button_debounce.sv
// button_debounce: conditions one raw active-low push-button.
//   sys_clk, reset_n - clock, async active-low reset
//   btn_n            - raw asynchronous button level (0 = pressed)
//   press            - one-cycle pulse when the debounced level falls
// A level change is accepted after DEBOUNCE_CYCLES consecutive cycles of the
// synchronised level disagreeing with the accepted level. Release is silent.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             synced;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  assign settle = (synced != stable) && (cnt == CNT_LAST);
  // Decoded from flops only, so the pulse is clean; it spans exactly the
  // cycle on whose closing edge stable drops to 0.
  assign press  = settle && stable;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b1;
      synced <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      meta   <= btn_n;
      synced <= meta;
      if (synced == stable) begin
        cnt <= '0;
      end else if (settle) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_time_core.sv
// clock_time_core: button front end, mode FSM and BCD HH:MM:SS counter.
//   sys_clk, reset_n       - clock, async active-low reset
//   mode_btn_n, set_btn_n  - raw active-low buttons
//   disp (master)          - digits, mode, blink mask, colon, sec_tick
// Mode FSM: CLOCK -> SET_MIN -> SET_HR -> CLOCK on each mode press; a mode
// press always wins over a set press arriving in the same cycle.
module clock_time_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ          = 27000000,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               mode_btn_n,
  input  logic               set_btn_n,
  clock_time_core_if.master  disp
);

  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_HZ / 2);

  logic             mode_press;
  logic             set_press;
  mode_t            mode;
  mode_t            mode_n;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_n;
  logic             phase;
  logic             phase_n;
  logic [3:0]       blink_n;
  logic             colon_n;
  logic             sec_tick_q;
  logic [3:0]       blink_q;
  logic             colon_q;
  bcd_t             sec_t, sec_o, min_t, min_o, hr_t, hr_o;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .btn_n   (mode_btn_n),
    .press   (mode_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_btn (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .btn_n   (set_btn_n),
    .press   (set_press)
  );

  // Next mode and divider; blink/colon are registered from these so they
  // change on the same edge as mode_state and the divider phase.
  always_comb begin
    mode_n = mode;
    div_n  = (div == DIV_LAST) ? '0 : div + 1'b1;
    case (mode)
      MODE_CLOCK: if (mode_press) mode_n = MODE_MIN;
      MODE_MIN:   if (mode_press) mode_n = MODE_HR;
      MODE_HR: begin
        if (mode_press) begin
          mode_n = MODE_CLOCK;
          div_n  = '0;  // full second before the first tick after setting
        end
      end
      default:    mode_n = MODE_CLOCK;
    endcase
    phase_n = (div_n < DIV_HALF);
    case (mode_n)
      MODE_MIN: blink_n = {2'b00, ~phase_n, ~phase_n};
      MODE_HR:  blink_n = {~phase_n, ~phase_n, 2'b00};
      default:  blink_n = 4'b0000;
    endcase
    colon_n = (mode_n == MODE_CLOCK) ? phase_n : 1'b1;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode       <= MODE_CLOCK;
      div        <= '0;
      phase      <= 1'b0;
      sec_tick_q <= 1'b0;
      blink_q    <= 4'b0000;
      colon_q    <= 1'b0;
      {sec_t, sec_o} <= 8'h00;
      {min_t, min_o} <= 8'h00;
      {hr_t, hr_o}   <= 8'h00;
    end else begin
      mode       <= mode_n;
      div        <= div_n;
      phase      <= phase_n;
      sec_tick_q <= (div_n == DIV_LAST);
      blink_q    <= blink_n;
      colon_q    <= colon_n;
      case (mode)
        MODE_CLOCK: begin
          if (mode_press) begin
            {sec_t, sec_o} <= 8'h00;
          end else if (sec_tick_q) begin
            {sec_t, sec_o} <= bcd_inc60(sec_t, sec_o);
            if (bcd_is59(sec_t, sec_o)) begin
              {min_t, min_o} <= bcd_inc60(min_t, min_o);
              if (bcd_is59(min_t, min_o)) {hr_t, hr_o} <= bcd_inc24(hr_t, hr_o);
            end
          end
        end
        MODE_MIN: if (!mode_press && set_press) {min_t, min_o} <= bcd_inc60(min_t, min_o);
        MODE_HR:  if (!mode_press && set_press) {hr_t, hr_o} <= bcd_inc24(hr_t, hr_o);
        default: ;
      endcase
    end
  end

  assign disp.dig3       = hr_t;
  assign disp.dig2       = hr_o;
  assign disp.dig1       = min_t;
  assign disp.dig0       = min_o;
  assign disp.mode_state = mode;
  assign disp.blink_mask = blink_q;
  assign disp.colon      = colon_q;
  assign disp.sec_tick   = sec_tick_q;

endmodule
